// File: rtl/axi_burst_master.sv
// AXI4 master bridge for one L1 cache port: line refills go out as INCR read bursts,
// write-through stores go out as single-beat writes with byte strobes.
module axi_burst_master #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned MST_ID    = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req,
   input  logic                           write,
   input  logic [ADDR_W-1:0]              addr,
   input  logic [DATA_W-1:0]              wdata,
   input  logic [DATA_W/8-1:0]            wstrb,
   output logic [DATA_W-1:0]              rdata,
   output logic                           rdata_valid,
   output logic [$clog2(BURST_LEN):0]     beat_idx,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [ID_W-1:0]                ARID,
   output logic [ADDR_W-1:0]              ARADDR,
   output logic [7:0]                     ARLEN,
   output logic [2:0]                     ARSIZE,
   output logic [1:0]                     ARBURST,
   output logic                           ARVALID,
   input  logic                           ARREADY,
   input  logic [ID_W-1:0]                RID,
   input  logic [DATA_W-1:0]              RDATA,
   input  logic [1:0]                     RRESP,
   input  logic                           RLAST,
   input  logic                           RVALID,
   output logic                           RREADY,
   output logic [ID_W-1:0]                AWID,
   output logic [ADDR_W-1:0]              AWADDR,
   output logic [7:0]                     AWLEN,
   output logic [2:0]                     AWSIZE,
   output logic [1:0]                     AWBURST,
   output logic                           AWVALID,
   input  logic                           AWREADY,
   output logic [DATA_W-1:0]              WDATA,
   output logic [DATA_W/8-1:0]            WSTRB,
   output logic                           WLAST,
   output logic                           WVALID,
   input  logic                           WREADY,
   input  logic [ID_W-1:0]                BID,
   input  logic [1:0]                     BRESP,
   input  logic                           BVALID,
   output logic                           BREADY
);

   localparam int unsigned BeatW = $clog2(BURST_LEN) + 1;
   localparam int unsigned OffW  = $clog2(BURST_LEN * DATA_W / 8);
   localparam logic [2:0]  Size  = 3'($clog2(DATA_W / 8));
   localparam logic [7:0]  Len   = 8'(BURST_LEN - 1);
   localparam logic [BeatW-1:0] LastIdx = BeatW'(BURST_LEN - 1);

   typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB} state_e;

   state_e              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [BeatW-1:0]    beat_q;
   logic                aw_done_q, w_done_q;
   logic                err_acc_q, err_q, done_q;
   logic                beat_err;
   logic                unused_ids;

   // IDs are not checked: only one transaction is ever outstanding.
   assign unused_ids = ^{RID, BID};

   // Bad response or RLAST on the wrong beat (early, late or missing).
   assign beat_err = (RRESP != 2'b00) || (RLAST != (beat_q == LastIdx));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         beat_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         err_acc_q <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            StIdle: begin
               if (req) begin
                  beat_q    <= '0;
                  err_acc_q <= 1'b0;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  if (write) begin
                     addr_q  <= addr;
                     wdata_q <= wdata;
                     wstrb_q <= wstrb;
                     state   <= StAww;
                  end else begin
                     addr_q <= {addr[ADDR_W-1:OffW], {OffW{1'b0}}};
                     state  <= StAr;
                  end
               end
            end
            StAr: begin
               if (ARREADY) state <= StR;
            end
            StR: begin
               if (RVALID) begin
                  beat_q    <= beat_q + 1'b1;
                  err_acc_q <= err_acc_q | beat_err;
                  if (RLAST) begin
                     err_q  <= err_acc_q | beat_err;
                     done_q <= 1'b1;
                     state  <= StIdle;
                  end
               end
            end
            StAww: begin
               if (AWREADY) aw_done_q <= 1'b1;
               if (WREADY)  w_done_q  <= 1'b1;
               if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state <= StB;
            end
            StB: begin
               if (BVALID) begin
                  err_q  <= (BRESP != 2'b00);
                  done_q <= 1'b1;
                  state  <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy        = (state != StIdle);
   assign done        = done_q;
   assign err         = err_q;
   assign beat_idx    = beat_q;
   assign rdata       = RDATA;
   assign rdata_valid = RVALID & RREADY;

   assign ARID    = ID_W'(MST_ID);
   assign ARADDR  = addr_q;
   assign ARLEN   = Len;
   assign ARSIZE  = Size;
   assign ARBURST = 2'b01;
   assign ARVALID = (state == StAr);
   assign RREADY  = (state == StR);

   assign AWID    = ID_W'(MST_ID);
   assign AWADDR  = addr_q;
   assign AWLEN   = 8'd0;
   assign AWSIZE  = Size;
   assign AWBURST = 2'b01;
   assign AWVALID = (state == StAww) && !aw_done_q;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;
   assign WLAST   = 1'b1;
   assign WVALID  = (state == StAww) && !w_done_q;
   assign BREADY  = (state == StB);

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Parametrised AXI4 master bridge between one L1 cache miss/write port and one AXI master slot on the bus.
- Supersedes the fixed single-beat per-channel wrapper FSMs.
- Issues cache-line refills as INCR bursts of BURST_LEN beats, and write-through stores as single beats with byte strobes.
- Drives AW and W concurrently, checks response codes and burst framing, and reports per-beat data plus a completion pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; one of 32 or 64.
- BURST_LEN, 4, read beats per line; power of 2, 1..16.
- ID_W, 4, AXI ID width.
- MST_ID, 0, constant driven on ARID/AWID.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req  in  1  transaction request, sampled in IDLE
- write  in  1  1 = single-beat write, 0 = line read
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables; 0 = no write
- rdata  out  DATA_W  read beat data (RDATA passthrough)
- rdata_valid  out  1  rdata beat valid this cycle
- beat_idx  out  $clog2(BURST_LEN)+1  index of the current read beat
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  error flag for the completed transaction, valid with done
- AR*: ARID, ARADDR, ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARVALID (out); ARREADY (in)
- R*: RID, RDATA, RRESP[1:0], RLAST, RVALID (in); RREADY (out)
- AW*: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in)
- W*: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in)
- B*: BID, BRESP, BVALID (in); BREADY (out)

Behaviour:
- Reset (rst=0, async): state IDLE; all VALID/READY outputs 0; done=0; err=0; beat_idx=0; address/data registers 0.
- IDLE:
  - busy=0.
  - If req=1 and write=0: latch addr with its low $clog2(BURST_LEN*DATA_W/8) bits cleared; go to AR.
  - If req=1 and write=1: latch addr, wdata and wstrb; go to AWW.
  - req is ignored whenever busy=1.
- AR:
  - ARVALID=1 with ARADDR=latched address, ARLEN=BURST_LEN-1, ARSIZE=$clog2(DATA_W/8), ARBURST=INCR (2'b01).
  - All AR fields are held stable until ARREADY. On the ARVALID&ARREADY cycle, go to R.
- R:
  - RREADY=1. rdata_valid = RVALID & RREADY; rdata = RDATA combinationally.
  - beat_idx increments on each accepted beat and starts at 0.
  - On an accepted beat with RLAST=1: go to IDLE.
  - err for a read is the OR of:
    - any RRESP != 2'b00 during the burst;
    - RLAST seen on a beat index other than BURST_LEN-1 (early last).
  - If BURST_LEN beats arrive without RLAST, keep accepting until RLAST; err=1.
- AWW:
  - AWVALID=1 and WVALID=1 are asserted in the same cycle.
  - AWLEN=0, AWSIZE as for AR, AWBURST=INCR, WLAST=1, WDATA/WSTRB from the latched values.
  - Each VALID drops independently after its own handshake. AWREADY and WREADY may complete in either order or in the same cycle.
  - When both handshakes are done, go to B.
- B:
  - BREADY=1. On BVALID: err = (BRESP != 2'b00); go to IDLE.
- done:
  - Registered; high for exactly the one cycle after the final R or B handshake, with state already IDLE.
  - A req presented while done=1 is accepted. Back-to-back transactions cost 1 IDLE cycle.
  - err holds its value until the next done.
- RID and BID are not checked; single outstanding transaction only.
- Reset mid-transaction: VALID outputs go to 0 immediately, and no done pulse is produced.

Test Plan:
- Read, req with addr=0x1000_0014, BURST_LEN=4, ARREADY delayed 2 cycles:
  - ARADDR=0x1000_0010, ARLEN=3, ARSIZE=2, ARBURST=1, held 3 cycles.
  - Beats 0xA0..0xA3 appear on rdata with beat_idx 0..3.
  - done=1 one cycle after RLAST, err=0.
- Write, addr=0x2000_0008, wdata=0xDEADBEEF, wstrb=4'b0011:
  - WREADY arrives 3 cycles before AWREADY. WVALID drops after its handshake; AWVALID holds until AWREADY.
  - BRESP=0 -> done, err=0.
- Write with AWREADY and WREADY both in the first cycle, then BRESP=2'b10 -> B entered next cycle; done with err=1.
- Read with RLAST on beat 1, BURST_LEN=4 -> done after beat 1, err=1. Read with RRESP=2'b11 on beat 2 -> err=1.
- Reset during R after 2 beats -> RREADY=0 and busy=0 in the same cycle; no done. A subsequent read completes cleanly.
- Back-to-back: a read req asserted during the done cycle of a write -> ARVALID rises the next cycle; no request is lost or duplicated.
